// File: rtl/aes_128_keysched_ctrl.sv
// aes_128_keysched_ctrl: AES-128 key-expansion sequencer.
// Accepts a cipher key over a valid/accept handshake and computes the 11 round keys.
// One round takes 5 cycles, and SubWord uses an external 2-cycle S-box BRAM.
// Each round key is written to the key RAM as two 64-bit halves.
// Optional feature: define AES_KEYSCHED_SAME_KEY_SKIP_EN to skip re-expanding a key
// that is already fully expanded and stored.
module aes_128_keysched_ctrl (
    input  logic         clk,
    input  logic         kill,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_accept,
    input  logic         core_idle,
    output logic         sbox_en,
    output logic [31:0]  sbox_addr,
    input  logic [31:0]  sbox_data,
    output logic         keyram_en_wr,
    output logic [63:0]  keyram_wr_data,
    output logic [3:0]   round_idx,
    output logic         key_ready,
    output logic         busy
);

    localparam int unsigned KEY_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned HALF_W = 64;
    localparam int unsigned RIDX_W = 4;
    localparam int unsigned BYTE_W = 8;

    localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(10);
    localparam logic [BYTE_W-1:0] RCON_INIT  = 8'h01;
    localparam logic [BYTE_W-1:0] RCON_POLY  = 8'h1b;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_WR_H = 3'd2,
        S_WR_L = 3'd3,
        S_SUB  = 3'd4,
        S_LAT  = 3'd5,
        S_EXP  = 3'd6
    } state_t;

    state_t              state;
    logic [KEY_W-1:0]    work_key;
    logic [BYTE_W-1:0]   rcon;

    logic [WORD_W-1:0]   w0, w1, w2, w3;
    logic [WORD_W-1:0]   t_word;
    logic [WORD_W-1:0]   n0, n1, n2, n3;
    logic [BYTE_W-1:0]   rcon_next;
    logic [WORD_W-1:0]   rot_w3;
    logic                same_key;

`ifdef AES_KEYSCHED_SAME_KEY_SKIP_EN
    logic [KEY_W-1:0]    last_key;

    // Offered key is already fully expanded in the key RAM
    always_comb begin
        same_key = 1'b0;
        if (key_ready && (key_in == last_key)) begin
            same_key = 1'b1;
        end
    end
`else
    // Without the skip feature every accepted key is expanded
    always_comb begin
        same_key = 1'b0;
    end
`endif

    // Split the working key into words and compute the next round's words
    always_comb begin
        w0        = work_key[KEY_W-1 -: WORD_W];
        w1        = work_key[KEY_W-1-WORD_W -: WORD_W];
        w2        = work_key[KEY_W-1-2*WORD_W -: WORD_W];
        w3        = work_key[WORD_W-1:0];
        rot_w3    = {w3[WORD_W-9:0], w3[WORD_W-1 -: BYTE_W]};
        t_word    = sbox_data ^ {rcon, 24'h000000};
        n0        = w0 ^ t_word;
        n1        = w1 ^ n0;
        n2        = w2 ^ n1;
        n3        = w3 ^ n2;
        rcon_next = {rcon[BYTE_W-2:0], 1'b0} ^ (rcon[BYTE_W-1] ? RCON_POLY : 8'h00);
    end

    // Sequencer: state, working key, rcon and all registered outputs
    always_ff @(posedge clk or negedge kill) begin
        if (!kill) begin
            state          <= S_IDLE;
            work_key       <= '0;
            rcon           <= RCON_INIT;
            round_idx      <= '0;
            key_ready      <= 1'b0;
            busy           <= 1'b0;
            key_accept     <= 1'b1;
            keyram_en_wr   <= 1'b0;
            keyram_wr_data <= '0;
            sbox_en        <= 1'b0;
            sbox_addr      <= '0;
`ifdef AES_KEYSCHED_SAME_KEY_SKIP_EN
            last_key       <= '0;
`endif
        end else begin
            keyram_en_wr <= 1'b0;
            sbox_en      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (key_valid && key_accept && !same_key) begin
                        state      <= S_WAIT;
                        work_key   <= key_in;
                        round_idx  <= '0;
                        rcon       <= RCON_INIT;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        key_accept <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (core_idle) begin
                        state          <= S_WR_H;
                        keyram_en_wr   <= 1'b1;
                        keyram_wr_data <= {w0, w1};
                    end
                end
                S_WR_H: begin
                    state          <= S_WR_L;
                    keyram_en_wr   <= 1'b1;
                    keyram_wr_data <= {w2, w3};
                end
                S_WR_L: begin
                    if (round_idx == LAST_ROUND) begin
                        state      <= S_IDLE;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                        key_accept <= 1'b1;
`ifdef AES_KEYSCHED_SAME_KEY_SKIP_EN
                        last_key   <= work_key;
`endif
                    end else begin
                        state     <= S_SUB;
                        sbox_en   <= 1'b1;
                        sbox_addr <= rot_w3;
                    end
                end
                S_SUB: begin
                    state <= S_LAT;
                end
                S_LAT: begin
                    state <= S_EXP;
                end
                S_EXP: begin
                    state          <= S_WR_H;
                    work_key       <= {n0, n1, n2, n3};
                    round_idx      <= round_idx + RIDX_W'(1);
                    rcon           <= rcon_next;
                    keyram_en_wr   <= 1'b1;
                    keyram_wr_data <= {n0, n1};
                end
                default: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    key_accept <= 1'b1;
                end
            endcase
        end
    end

    // HALF_W documents the key RAM word size used by keyram_wr_data
    localparam int unsigned KEYRAM_HALVES = KEY_W / HALF_W;
    if (KEYRAM_HALVES != 2) begin : g_bad_split
        $error("key must split into two key RAM words");
    end

endmodule

// File: tb/tb_aes_128_keysched_ctrl.sv
// Directed bench for aes_128_keysched_ctrl using FIPS-197 and all-zero key vectors.
`timescale 1ns/1ps
module tb_aes_128_keysched_ctrl;

    logic         clk = 1'b0;
    logic         kill = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_accept;
    logic         core_idle = 1'b1;
    logic         sbox_en;
    logic [31:0]  sbox_addr;
    logic [31:0]  sbox_data = '0;
    logic         keyram_en_wr;
    logic [63:0]  keyram_wr_data;
    logic [3:0]   round_idx;
    logic         key_ready;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    aes_128_keysched_ctrl dut (
        .clk            (clk),
        .kill           (kill),
        .key_in         (key_in),
        .key_valid      (key_valid),
        .key_accept     (key_accept),
        .core_idle      (core_idle),
        .sbox_en        (sbox_en),
        .sbox_addr      (sbox_addr),
        .sbox_data      (sbox_data),
        .keyram_en_wr   (keyram_en_wr),
        .keyram_wr_data (keyram_wr_data),
        .round_idx      (round_idx),
        .key_ready      (key_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    logic [127:0] fips_rk [11];
    logic [7:0]   sbox_rom [256];

    initial begin
        fips_rk = '{
            128'h2b7e151628aed2a6abf7158809cf4f3c,
            128'ha0fafe1788542cb123a339392a6c7605,
            128'hf2c295f27a96b9435935807a7359f67f,
            128'h3d80477d4716fe3e1e237e446d7a883b,
            128'hef44a541a8525b7fb671253bdb0bad00,
            128'hd4d1c6f87c839d87caf2b8bc11f915bc,
            128'h6d88a37a110b3efddbf98641ca0093fd,
            128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
            128'head27321b58dbad2312bf5607f8d292f,
            128'hac7766f319fadc2128d12941575c006e,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        sbox_rom = '{
            8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
            8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
            8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
            8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
            8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
            8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
            8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
            8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
            8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
            8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
            8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
            8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
            8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
            8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
            8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
            8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
    end

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_rom[w[31:24]], sbox_rom[w[23:16]], sbox_rom[w[15:8]], sbox_rom[w[7:0]]};
    endfunction

    // S-box BRAM: address registered, then output register -> data 2 cycles after strobe
    logic [31:0] sb_stage = '0;
    always @(posedge clk) begin
        sb_stage  <= sbox_en ? sub_word(sbox_addr) : 32'h0;
        sbox_data <= sb_stage;
    end

    // Edge counter; an observation at a negedge is labelled edge_cnt+1
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int          acc_q [$];
    int          rdy_q [$];
    logic [67:0] wr_q [$];
    int          wr_lbl_q [$];
    int          sbox_cnt = 0;
    logic [31:0] sbox_addr1 = '0;
    int          run_len = 0;
    int          max_run = 0;
    int          busy_cnt = 0;
    int          accept_viol = 0;
    logic        rdy_prev = 1'b0;

    // Passive monitor sampling outputs mid-cycle
    always @(negedge clk) begin
        if (kill && key_valid && key_accept) acc_q.push_back(edge_cnt + 1);
        if (key_ready && !rdy_prev) rdy_q.push_back(edge_cnt + 1);
        rdy_prev = key_ready;
        if (keyram_en_wr) begin
            wr_q.push_back({round_idx, keyram_wr_data});
            wr_lbl_q.push_back(edge_cnt + 1);
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (sbox_en) begin
            if (sbox_cnt == 0) sbox_addr1 = sbox_addr;
            sbox_cnt++;
        end
        if (busy) busy_cnt++;
        if (key_accept == busy) accept_viol++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [67:0] get_wr(input int k);
        if (wr_q.size() > k) return wr_q[k];
        return '1;
    endfunction

    function automatic int get_lbl(input int k);
        if (wr_lbl_q.size() > k) return wr_lbl_q[k];
        return -1000;
    endfunction

    function automatic int get_acc(input int k);
        if (acc_q.size() > k) return acc_q[k];
        return -2000;
    endfunction

    function automatic int get_rdy(input int k);
        if (rdy_q.size() > k) return rdy_q[k];
        return -3000;
    endfunction

    function automatic logic [67:0] exp_wr(input logic [127:0] rk, input int k);
        return {4'(k / 2), (k % 2 == 0) ? rk[127:64] : rk[63:0]};
    endfunction

    task automatic clear_logs();
        acc_q.delete();
        rdy_q.delete();
        wr_q.delete();
        wr_lbl_q.delete();
        sbox_cnt    = 0;
        max_run     = 0;
        busy_cnt    = 0;
        accept_viol = 0;
    endtask

    // Offer a key starting just after a posedge; returns 1ns after the handshake edge
    task automatic offer(input logic [127:0] k);
        int n0;
        n0 = acc_q.size();
        key_in    = k;
        key_valid = 1'b1;
        for (int i = 0; i < 100 && acc_q.size() == n0; i++) begin
            @(posedge clk);
            #1;
        end
        key_valid = 1'b0;
        check("accept_seen", 128'(acc_q.size() - n0), 128'd1);
    endtask

    task automatic wait_ready(input int n);
        for (int i = 0; i < 300 && rdy_q.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        check("ready_timeout", 128'(rdy_q.size() >= n), 128'd1);
    endtask

    task automatic check_fips_sched(input string tag, input int base);
        for (int k = 0; k < 22; k++) begin
            check($sformatf("%s_wr%0d", tag, k), 128'(get_wr(base + k)), 128'(exp_wr(fips_rk[k / 2], k)));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Reset state
        #12;
        check("rst_ctrl", 128'({key_accept, busy, key_ready, keyram_en_wr, sbox_en, round_idx}), 128'h100);
        check("rst_data", 128'({keyram_wr_data, sbox_addr}), 128'h0);
        @(posedge clk);
        #1;
        kill = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // FIPS-197 key, core idle
        clear_logs();
        offer(FIPS_KEY);
        wait_ready(1);
        t = get_acc(0);
        check("fips_nwr", 128'(wr_q.size()), 128'd22);
        check_fips_sched("fips", 0);
        check("fips_first_wr", 128'(get_lbl(0) - t), 128'd2);
        check("fips_last_wr", 128'(get_lbl(21) - t), 128'd53);
        check("fips_ready", 128'(get_rdy(0) - t), 128'd54);
        check("fips_nsbox", 128'(sbox_cnt), 128'd10);
        check("fips_sbox_addr1", 128'(sbox_addr1), 128'hcf4f3c09);
        check("fips_max_run", 128'(max_run), 128'd2);
        check("fips_accept_busy", 128'(accept_viol), 128'd0);
        check("fips_end_flags", 128'({key_ready, busy, key_accept}), 128'b101);

        // Idle gating: core_idle low for 7 cycles after accept (all-zero key)
        clear_logs();
        core_idle = 1'b0;
        offer(ZERO_KEY);
        repeat (7) @(posedge clk);
        #1;
        core_idle = 1'b1;
        wait_ready(1);
        t = get_acc(0);
        check("gate_nwr", 128'(wr_q.size()), 128'd22);
        check("gate_first_wr", 128'(get_lbl(0) - t), 128'd9);
        check("gate_ready", 128'(get_rdy(0) - t), 128'd61);
        check("gate_wr0", 128'(get_wr(0)), 128'(68'h0));
        check("gate_wr2", 128'(get_wr(2)), 128'({4'd1, 64'h6263636362636363}));
        check("gate_wr21", 128'(get_wr(21)), 128'({4'd10, 64'h23e951cf6f8f188e}));

        // Busy handshake: second key held pending through the first expansion
        clear_logs();
        offer(FIPS_KEY);
        key_in    = ZERO_KEY;
        key_valid = 1'b1;
        for (int i = 0; i < 100 && acc_q.size() < 2; i++) begin
            @(posedge clk);
            #1;
        end
        key_valid = 1'b0;
        check("busy_second_accept", 128'(get_acc(1) - get_acc(0)), 128'd54);
        wait_ready(2);
        check("busy_accept_busy", 128'(accept_viol), 128'd0);
        check("busy_nwr", 128'(wr_q.size()), 128'd44);
        check("busy_wr21", 128'(get_wr(21)), 128'(exp_wr(fips_rk[10], 21)));
        check("busy_wr22", 128'(get_wr(22)), 128'(68'h0));
        check("busy_wr43", 128'(get_wr(43)), 128'({4'd10, 64'h23e951cf6f8f188e}));
        check("busy_second_first_wr", 128'(get_lbl(22) - get_acc(1)), 128'd2);

        // Kill during round 5 EXP, then re-expand the same key
        clear_logs();
        offer(FIPS_KEY);
        repeat (30) @(posedge clk);
        #2;
        check("kill_pre", 128'({busy, round_idx}), 128'({1'b1, 4'd5}));
        kill = 1'b0;
        #1;
        check("kill_ctrl", 128'({key_accept, busy, key_ready, keyram_en_wr, sbox_en, round_idx}), 128'h100);
        check("kill_data", 128'({keyram_wr_data, sbox_addr}), 128'h0);
        repeat (2) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
        offer(FIPS_KEY);
        wait_ready(1);
        t = get_acc(0);
        check("rekey_nwr", 128'(wr_q.size()), 128'd22);
        check_fips_sched("rekey", 0);
        check("rekey_ready", 128'(get_rdy(0) - t), 128'd54);

        // Same key offered again after key_ready
        clear_logs();
        offer(FIPS_KEY);
`ifdef AES_KEYSCHED_SAME_KEY_SKIP_EN
        repeat (60) @(posedge clk);
        #1;
        check("skip_nwr", 128'(wr_q.size()), 128'd0);
        check("skip_busy", 128'(busy_cnt), 128'd0);
        check("skip_ready", 128'(key_ready), 128'd1);
        clear_logs();
        offer(ZERO_KEY);
        wait_ready(1);
        check("skip_diff_nwr", 128'(wr_q.size()), 128'd22);
        check("skip_diff_wr43", 128'(get_wr(21)), 128'({4'd10, 64'h23e951cf6f8f188e}));
`else
        wait_ready(1);
        check("same_nwr", 128'(wr_q.size()), 128'd22);
        check("same_ready", 128'(get_rdy(0) - get_acc(0)), 128'd54);
        check("same_wr21", 128'(get_wr(21)), 128'(exp_wr(fips_rk[10], 21)));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_128_keysched_ctrl.md
# aes_128_keysched_ctrl

Key-expansion sequencer for the 128-bit AES core. It accepts a cipher key through a valid/accept handshake and computes the 11 round keys, one round per 5 cycles. A shared external S-box BRAM performs the SubWord step. Each round key is written into the key RAM as two 64-bit halves, and `key_ready` is raised once the whole schedule is stored. The block sits between the key-load interface and the key RAM write port, and it only overwrites the RAM while the datapath reports idle.

## Interface
- No parameters; key width 128 and 10 rounds are fixed.
- `clk`  in  1  single clock, all logic on rising edge
- `kill`  in  1  reset, asynchronous, active-low
- `key_in`  in  128  cipher key, w0 = `key_in[127:96]` … w3 = `key_in[31:0]`
- `key_valid`  in  1  key offer
- `key_accept`  out  1  controller can take a key (IDLE)
- `core_idle`  in  1  datapath not reading key RAM
- `sbox_en`  out  1  S-box read strobe
- `sbox_addr`  out  32  four byte addresses = RotWord(w3)
- `sbox_data`  in  32  S-box result, valid 2 cycles after `sbox_en`
- `keyram_en_wr`  out  1  key RAM write strobe; sink advances its address per strobe
- `keyram_wr_data`  out  64  round-key half
- `round_idx`  out  4  round currently written, 0..10
- `key_ready`  out  1  complete schedule stored in key RAM
- `busy`  out  1  expansion in progress (not IDLE)

## Operation
- States: IDLE, WAIT, WR_H, WR_L, SUB, LAT, EXP.
- IDLE: `key_accept`=1. When `key_valid & key_accept` at an edge, capture `key_in` into the working key register, clear `round_idx`, deassert `key_ready`, and go to WAIT.
- WAIT: go to WR_H when `core_idle`=1, otherwise hold.
- WR_H: `keyram_en_wr`=1, data = {w0,w1}; next state WR_L.
- WR_L: `keyram_en_wr`=1, data = {w2,w3}. If `round_idx`=10, set `key_ready` and go to IDLE. Otherwise go to SUB.
- SUB: `sbox_en`=1, `sbox_addr` = {w3[23:0],w3[31:24]}; next state LAT.
- LAT: wait for BRAM output register; next state EXP.
- EXP: t = `sbox_data` ^ {rcon,24'h0}.
  - Update words: w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - Increment `round_idx` and advance rcon; then go to WR_H.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36. Advance by xtime (shift left 1; if the old MSB was 1, XOR 1b).
- `core_idle` is checked only in WAIT. Once the first write starts, all 22 writes complete regardless of `core_idle`.
- `key_valid` is ignored while `busy`. The offered key stays pending at the source until `key_accept`.
- Outputs are decoded from the registered state and are glitch-free. `keyram_wr_data` and `sbox_addr` are don't-care when their strobes are low, but are driven with no X.
- `kill` low at any point, including mid-expansion:
  - state → IDLE;
  - `key_ready`, `busy`, `keyram_en_wr`, `sbox_en` = 0;
  - `round_idx` = 0;
  - key registers = 0;
  - rcon = 01.
- Key RAM contents are then partial. The RAM address is the sink's responsibility, and `key_ready` stays 0 until a new full expansion.

## Timing
- Reset values: `key_accept`=1, `busy`=0, `key_ready`=0, `keyram_en_wr`=0, `sbox_en`=0, `round_idx`=0, `keyram_wr_data`=0, `sbox_addr`=0.
- Handshake at edge T with `core_idle`=1 gives the following cycle timeline:
  - T+1: WAIT.
  - T+2: WR_H for round 0.
  - Round r: WR_H at T+2+5r, WR_L at T+3+5r.
- The last write (round 10 WR_L) is at T+53.
- `key_ready`=1, `busy`=0 and `key_accept`=1 from T+54.
- There are exactly 22 `keyram_en_wr` cycles per expansion, in pairs, never more than 2 consecutive.
- Each cycle spent in WAIT adds one cycle to every subsequent timestamp.

## Configuration
- `AES_KEYSCHED_SAME_KEY_SKIP_EN` defined:
  - A second 128-bit register holds the last fully expanded key.
  - On accept with `key_ready`=1 and `key_in` equal to that key, the controller stays in IDLE. There are no writes, `key_ready` remains 1 and `busy` never rises.
  - The register is cleared by `kill`.
  - A killed or partial expansion never matches.
- Undefined: every accepted key runs the full expansion. `key_ready` drops the cycle after accept.

## Test plan
- **FIPS-197 key:** `key_in`=2b7e151628aed2a6abf7158809cf4f3c, `core_idle`=1.
  - Write 0 = 2b7e151628aed2a6 at T+2.
  - Round 1 = a0fafe1788542cb1 / 23a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589 / e13f0cc8b6630ca6.
  - `key_ready` at T+54, with 22 strobes total.
- **Idle gating:** `core_idle`=0 for 7 cycles after accept → no write until `core_idle`=1; first WR_H 1 cycle after `core_idle` rises; `key_ready` at T+61.
- **Busy handshake:** `key_valid` held high with a second key during expansion → `key_accept`=0 throughout; second key accepted at T+54; its schedule follows.
- **Kill mid-expansion:** assert `kill` low during round 5 EXP → all outputs return to reset values asynchronously. After release, the same key re-expands from round 0 with the FIPS vectors intact.
- **Same-key skip:** with `AES_KEYSCHED_SAME_KEY_SKIP_EN`, re-offer the FIPS key after `key_ready` → zero `keyram_en_wr`, `busy`=0. A different key → full 22-write expansion. Without the macro, the same key → full expansion.
- **S-box latency:** bench S-box model returns data exactly 2 cycles after `sbox_en`. Check 10 `sbox_en` pulses, one per round, with `sbox_addr` for round 1 = cf4f3c09.
